// File: rtl/fetch_line_responder_if.sv
// Request, instruction-bus and response signals of the line-fill responder.
// master = fetch buffer / bus model side, slave = fetch_line_responder.
interface fetch_line_responder_if #(
    parameter int unsigned PA_BITS = 34,
    parameter int unsigned LINELEN = 512,
    parameter int unsigned BUSW    = 64
);
    // Request side
    logic               ReqValid;
    logic               ReqReady;
    logic [PA_BITS-1:0] ReqPAdr;
    logic               ReqPrefetch;
    logic               Flush;

    // Instruction bus side
    logic               BusReq;
    logic [PA_BITS-1:0] BusAdr;
    logic               BusBeatValid;
    logic [BUSW-1:0]    BusData;
    logic               BusErr;

    // Response side
    logic               RespValid;
    logic               RespReady;
    logic [LINELEN-1:0] RespLine;
    logic [PA_BITS-1:0] RespPAdr;
    logic               RespPrefetch;
    logic               RespErr;

    modport master (
        output ReqValid, ReqPAdr, ReqPrefetch, Flush,
        output BusBeatValid, BusData, BusErr,
        output RespReady,
        input  ReqReady, BusReq, BusAdr,
        input  RespValid, RespLine, RespPAdr, RespPrefetch, RespErr
    );

    modport slave (
        input  ReqValid, ReqPAdr, ReqPrefetch, Flush,
        input  BusBeatValid, BusData, BusErr,
        input  RespReady,
        output ReqReady, BusReq, BusAdr,
        output RespValid, RespLine, RespPAdr, RespPrefetch, RespErr
    );
endinterface

// File: rtl/fetch_line_responder.sv
// Line-fill responder: accepts one line request, bursts BEATS bus beats, assembles the line
// and hands it back with its aligned address, prefetch tag and sticky error flag.
// Optional feature: define FETCHRESP_LASTLINE_EN to keep the last error-free line in a
// one-entry holding register and answer repeat requests without a bus burst.
module fetch_line_responder #(
    parameter int unsigned PA_BITS = 34,
    parameter int unsigned LINELEN = 512,
    parameter int unsigned BUSW    = 64
) (
    input logic                  clk,
    input logic                  reset,   // asynchronous, active low
    fetch_line_responder_if.slave fif
);
    localparam int unsigned BEATS      = LINELEN / BUSW;
    localparam int unsigned CNT_W      = $clog2(BEATS);
    localparam int unsigned LINE_BYTES = LINELEN / 8;
    localparam int unsigned BEAT_BYTES = BUSW / 8;

    typedef enum logic [1:0] {StIdle, StBurst, StResp, StDrain} state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [LINELEN-1:0] line_q;
    logic [PA_BITS-1:0] padr_q;
    logic [PA_BITS-1:0] bus_adr_q;
    logic               pf_q;
    logic               err_q;
    logic               req_ready_q;
    logic               bus_req_q;
    logic               resp_valid_q;

    logic [PA_BITS-1:0] req_aligned;
    logic               accept;
    logic               last_beat;
    logic [LINELEN-1:0] line_next;

`ifdef FETCHRESP_LASTLINE_EN
    logic               hold_valid_q;
    logic [PA_BITS-1:0] hold_adr_q;
    logic [LINELEN-1:0] hold_line_q;
    logic               hold_hit;
`endif

    assign req_aligned = fif.ReqPAdr & ~PA_BITS'(LINE_BYTES - 1);
    assign accept      = fif.ReqValid & req_ready_q & ~fif.Flush;
    assign last_beat   = (cnt_q == CNT_W'(BEATS - 1));

`ifdef FETCHRESP_LASTLINE_EN
    assign hold_hit = hold_valid_q && (hold_adr_q == req_aligned);
`endif

    // Line image with the incoming beat merged into its slot
    always_comb begin
        line_next = line_q;
        line_next[cnt_q*BUSW +: BUSW] = fif.BusData;
    end

    // Control FSM with registered handshake outputs and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            line_q       <= '0;
            padr_q       <= '0;
            bus_adr_q    <= '0;
            pf_q         <= 1'b0;
            err_q        <= 1'b0;
            req_ready_q  <= 1'b1;
            bus_req_q    <= 1'b0;
            resp_valid_q <= 1'b0;
`ifdef FETCHRESP_LASTLINE_EN
            hold_valid_q <= 1'b0;
            hold_adr_q   <= '0;
            hold_line_q  <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        padr_q      <= req_aligned;
                        bus_adr_q   <= req_aligned;
                        pf_q        <= fif.ReqPrefetch;
                        err_q       <= 1'b0;
                        cnt_q       <= '0;
                        req_ready_q <= 1'b0;
`ifdef FETCHRESP_LASTLINE_EN
                        if (hold_hit) begin
                            line_q       <= hold_line_q;
                            state_q      <= StResp;
                            resp_valid_q <= 1'b1;
                        end else begin
                            state_q   <= StBurst;
                            bus_req_q <= 1'b1;
                        end
`else
                        state_q   <= StBurst;
                        bus_req_q <= 1'b1;
`endif
                    end
                end
                StBurst: begin
                    if (fif.BusBeatValid) begin
                        cnt_q     <= cnt_q + CNT_W'(1);
                        bus_adr_q <= bus_adr_q + PA_BITS'(BEAT_BYTES);
                        line_q    <= line_next;
                        err_q     <= err_q | fif.BusErr;
                        if (last_beat) begin
                            bus_req_q <= 1'b0;
                            if (fif.Flush) begin
                                state_q     <= StIdle;
                                req_ready_q <= 1'b1;
                            end else begin
                                state_q      <= StResp;
                                resp_valid_q <= 1'b1;
`ifdef FETCHRESP_LASTLINE_EN
                                if (!(err_q | fif.BusErr)) begin
                                    hold_valid_q <= 1'b1;
                                    hold_adr_q   <= padr_q;
                                    hold_line_q  <= line_next;
                                end
`endif
                            end
                        end else if (fif.Flush) begin
                            state_q   <= StDrain;
                            bus_req_q <= 1'b0;
                        end
                    end else if (fif.Flush) begin
                        state_q   <= StDrain;
                        bus_req_q <= 1'b0;
                    end
                end
                StResp: begin
                    // A flush drops the line exactly like a consumer handshake would
                    if (fif.Flush || fif.RespReady) begin
                        state_q      <= StIdle;
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                    end
                end
                StDrain: begin
                    // Swallow the rest of the burst so the bus sees a complete transfer
                    if (fif.BusBeatValid) begin
                        cnt_q     <= cnt_q + CNT_W'(1);
                        bus_adr_q <= bus_adr_q + PA_BITS'(BEAT_BYTES);
                        if (last_beat) begin
                            state_q     <= StIdle;
                            req_ready_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q      <= StIdle;
                    req_ready_q  <= 1'b1;
                    bus_req_q    <= 1'b0;
                    resp_valid_q <= 1'b0;
                end
            endcase
`ifdef FETCHRESP_LASTLINE_EN
            if (fif.Flush) begin
                hold_valid_q <= 1'b0;
            end
`endif
        end
    end

    assign fif.ReqReady     = req_ready_q;
    assign fif.BusReq       = bus_req_q;
    assign fif.BusAdr       = bus_adr_q;
    assign fif.RespValid    = resp_valid_q;
    assign fif.RespLine     = line_q;
    assign fif.RespPAdr     = padr_q;
    assign fif.RespPrefetch = pf_q;
    assign fif.RespErr      = err_q;
endmodule

// File: tb/tb_fetch_line_responder.sv
// Self-checking bench for fetch_line_responder (LINELEN=512, BUSW=64, BEATS=8).
// Table-driven bursts plus hand-written reset and holding-register sequences.
module tb_fetch_line_responder;
    localparam int unsigned PA_BITS = 34;
    localparam int unsigned LINELEN = 512;
    localparam int unsigned BUSW    = 64;
    localparam int          NVEC    = 7;

    typedef struct {
        logic [PA_BITS-1:0] addr;
        logic               pf;
        int                 err_beat;   // -1: no error
        int                 flush_at;   // beat index carrying Flush, -1: none
        int                 stall;      // cycles RespReady held low
        bit                 pre_flush;  // Flush+ReqValid in IDLE first (must be ignored)
        bit                 resp_flush; // end RESP with Flush instead of RespReady
        bit                 exp_resp;
        bit                 exp_err;
        logic [PA_BITS-1:0] exp_padr;
    } vec_t;

    logic clk;
    logic reset;
    int   errors;
    int   checks;
    vec_t vecs[NVEC];
    vec_t hv;

    fetch_line_responder_if #(.PA_BITS(PA_BITS), .LINELEN(LINELEN), .BUSW(BUSW)) fif ();

    fetch_line_responder #(.PA_BITS(PA_BITS), .LINELEN(LINELEN), .BUSW(BUSW)) dut (
        .clk   (clk),
        .reset (reset),
        .fif   (fif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [LINELEN-1:0] act,
                       input logic [LINELEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [BUSW-1:0] beat_data(input logic [PA_BITS-1:0] a, input int k);
        logic [7:0] kb;
        kb = 8'(k);
        return {a[31:0], 16'hBEEF, 8'h5A, kb};
    endfunction

    function automatic logic [LINELEN-1:0] model_line(input logic [PA_BITS-1:0] a);
        logic [LINELEN-1:0] l;
        l = '0;
        for (int k = 0; k < 8; k++) l[k*BUSW +: BUSW] = beat_data(a, k);
        return l;
    endfunction

    task automatic do_burst(input vec_t v);
        logic [LINELEN-1:0] exp_line;
        bit                 exp_breq;
        exp_line = model_line(v.exp_padr);
        @(negedge clk);
        if (v.pre_flush) begin
            fif.ReqValid    = 1'b1;
            fif.ReqPAdr     = v.addr;
            fif.ReqPrefetch = v.pf;
            fif.Flush       = 1'b1;
            @(negedge clk);
            fif.Flush    = 1'b0;
            fif.ReqValid = 1'b0;
            chk("flush_idle_busreq", LINELEN'(fif.BusReq), LINELEN'(0));
            chk("flush_idle_ready", LINELEN'(fif.ReqReady), LINELEN'(1));
        end
        chk("idle_ready", LINELEN'(fif.ReqReady), LINELEN'(1));
        fif.ReqValid    = 1'b1;
        fif.ReqPAdr     = v.addr;
        fif.ReqPrefetch = v.pf;
        @(negedge clk);
        fif.ReqValid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            exp_breq = (v.flush_at < 0) || (k <= v.flush_at);
            chk("bus_req", LINELEN'(fif.BusReq), LINELEN'(exp_breq));
            if (exp_breq) chk("bus_adr", LINELEN'(fif.BusAdr), LINELEN'(v.exp_padr + 34'(8 * k)));
            if (k == 7) chk("resp_early", LINELEN'(fif.RespValid), LINELEN'(0));
            fif.BusBeatValid = 1'b1;
            fif.BusData      = beat_data(v.exp_padr, k);
            fif.BusErr       = (k == v.err_beat);
            fif.Flush        = (k == v.flush_at);
            @(negedge clk);
        end
        fif.BusBeatValid = 1'b0;
        fif.BusErr       = 1'b0;
        fif.Flush        = 1'b0;
        if (!v.exp_resp) begin
            chk("no_resp", LINELEN'(fif.RespValid), LINELEN'(0));
            chk("ready_after_drain", LINELEN'(fif.ReqReady), LINELEN'(1));
            chk("busreq_after_drain", LINELEN'(fif.BusReq), LINELEN'(0));
        end else begin
            for (int s = 0; s <= v.stall; s++) begin
                chk("resp_valid", LINELEN'(fif.RespValid), LINELEN'(1));
                chk("resp_ready_low", LINELEN'(fif.ReqReady), LINELEN'(0));
                chk("resp_padr", LINELEN'(fif.RespPAdr), LINELEN'(v.exp_padr));
                chk("resp_pf", LINELEN'(fif.RespPrefetch), LINELEN'(v.pf));
                chk("resp_err", LINELEN'(fif.RespErr), LINELEN'(v.exp_err));
                chk("resp_busreq", LINELEN'(fif.BusReq), LINELEN'(0));
                if (!v.exp_err) chk("resp_line", fif.RespLine, exp_line);
                if (s < v.stall) @(negedge clk);
            end
            if (v.resp_flush) fif.Flush = 1'b1;
            else fif.RespReady = 1'b1;
            @(negedge clk);
            fif.Flush     = 1'b0;
            fif.RespReady = 1'b0;
            chk("resp_done", LINELEN'(fif.RespValid), LINELEN'(0));
            chk("ready_after_resp", LINELEN'(fif.ReqReady), LINELEN'(1));
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        //          addr              pf  err flush stall pre rf  resp err padr
        vecs[0] = '{34'h0_8000_0044, 1'b0, -1, -1, 0, 1'b0, 1'b0, 1'b1, 1'b0, 34'h0_8000_0040};
        vecs[1] = '{34'h0_8000_0044, 1'b0, -1, -1, 5, 1'b1, 1'b0, 1'b1, 1'b0, 34'h0_8000_0040};
        vecs[2] = '{34'h0_8000_1000, 1'b1, -1,  3, 0, 1'b0, 1'b0, 1'b0, 1'b0, 34'h0_8000_1000};
        vecs[3] = '{34'h0_8000_2088, 1'b1,  5, -1, 0, 1'b0, 1'b0, 1'b1, 1'b1, 34'h0_8000_2080};
        vecs[4] = '{34'h0_8000_20C0, 1'b0, -1, -1, 2, 1'b0, 1'b0, 1'b1, 1'b0, 34'h0_8000_20C0};
        vecs[5] = '{34'h3_0000_0F3F, 1'b1, -1,  7, 0, 1'b0, 1'b0, 1'b0, 1'b0, 34'h3_0000_0F00};
        vecs[6] = '{34'h0_8000_3010, 1'b1, -1, -1, 1, 1'b0, 1'b1, 1'b1, 1'b0, 34'h0_8000_3000};

        reset            = 1'b0;
        fif.ReqValid     = 1'b0;
        fif.ReqPAdr      = '0;
        fif.ReqPrefetch  = 1'b0;
        fif.Flush        = 1'b0;
        fif.BusBeatValid = 1'b0;
        fif.BusData      = '0;
        fif.BusErr       = 1'b0;
        fif.RespReady    = 1'b0;
        #12;
        chk("rst_req_ready", LINELEN'(fif.ReqReady), LINELEN'(1));
        chk("rst_bus_req", LINELEN'(fif.BusReq), LINELEN'(0));
        chk("rst_bus_adr", LINELEN'(fif.BusAdr), LINELEN'(0));
        chk("rst_resp_valid", LINELEN'(fif.RespValid), LINELEN'(0));
        chk("rst_resp_line", fif.RespLine, LINELEN'(0));
        chk("rst_resp_padr", LINELEN'(fif.RespPAdr), LINELEN'(0));
        chk("rst_resp_err", LINELEN'(fif.RespErr), LINELEN'(0));
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < NVEC; i++) do_burst(vecs[i]);

        // Reset asserted in the middle of a burst, after four beats
        @(negedge clk);
        fif.ReqValid = 1'b1;
        fif.ReqPAdr  = 34'h0_8000_4000;
        @(negedge clk);
        fif.ReqValid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            fif.BusBeatValid = 1'b1;
            fif.BusData      = beat_data(34'h0_8000_4000, k);
            @(negedge clk);
        end
        reset            = 1'b0;
        fif.BusBeatValid = 1'b0;
        #1;
        chk("midrst_bus_req", LINELEN'(fif.BusReq), LINELEN'(0));
        chk("midrst_resp_valid", LINELEN'(fif.RespValid), LINELEN'(0));
        chk("midrst_req_ready", LINELEN'(fif.ReqReady), LINELEN'(1));
        @(negedge clk);
        reset = 1'b1;
        hv = '{34'h0_8000_5008, 1'b0, -1, -1, 0, 1'b0, 1'b0, 1'b1, 1'b0, 34'h0_8000_5000};
        do_burst(hv);

        // Repeat request into the line fetched by vecs[0]
        do_burst(vecs[0]);
`ifdef FETCHRESP_LASTLINE_EN
        @(negedge clk);
        fif.ReqValid    = 1'b1;
        fif.ReqPAdr     = 34'h0_8000_0050;
        fif.ReqPrefetch = 1'b1;
        @(negedge clk);
        fif.ReqValid = 1'b0;
        chk("hit_resp_valid", LINELEN'(fif.RespValid), LINELEN'(1));
        chk("hit_bus_req", LINELEN'(fif.BusReq), LINELEN'(0));
        chk("hit_line", fif.RespLine, model_line(34'h0_8000_0040));
        chk("hit_padr", LINELEN'(fif.RespPAdr), LINELEN'(34'h0_8000_0040));
        chk("hit_pf", LINELEN'(fif.RespPrefetch), LINELEN'(1));
        chk("hit_err", LINELEN'(fif.RespErr), LINELEN'(0));
        fif.RespReady = 1'b1;
        @(negedge clk);
        fif.RespReady = 1'b0;
        chk("hit_done", LINELEN'(fif.RespValid), LINELEN'(0));
        fif.Flush = 1'b1;
        @(negedge clk);
        fif.Flush = 1'b0;
`endif
        // Without a valid holding entry this must be a full burst
        hv = '{34'h0_8000_0050, 1'b1, -1, -1, 0, 1'b0, 1'b0, 1'b1, 1'b0, 34'h0_8000_0040};
        do_burst(hv);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
